// File: rtl/route_out_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : route_out_stage_if
// Description : Flit input handshake, three-port output handshake and status
//               bundle for the route output stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface route_out_stage_if #(
  parameter int DATA_W = 30
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_head;
  logic              in_tail;
  logic [2:0]        in_route;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_tail;
  logic              busy;
  logic [7:0]        drop_cnt;
  logic [7:0]        err_cnt;

  // Design side
  modport slave (
    input  in_valid, in_data, in_head, in_tail, in_route, out_ready,
    output in_ready, out_valid, out_data, out_tail, busy, drop_cnt, err_cnt
  );

  // Environment side
  modport master (
    output in_valid, in_data, in_head, in_tail, in_route, out_ready,
    input  in_ready, out_valid, out_data, out_tail, busy, drop_cnt, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/route_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : route_out_stage
// Description : Output stage of a router. Buffers flits in a small FIFO and
//               steers whole packets to one of three output ports, dropping
//               packets with an invalid route and discarding orphan flits.
// Revision    : 1.0 - initial release
// ============================================================================
module route_out_stage #(
  parameter int DATA_W = 30,
  parameter int DEPTH  = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  route_out_stage_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_DROP   = 2'd2;

  // FIFO storage (no reset needed: occupancy qualifies every read)
  logic [DATA_W-1:0] mem_data_q  [DEPTH];
  logic              mem_head_q  [DEPTH];
  logic              mem_tail_q  [DEPTH];
  logic [2:0]        mem_route_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q,  count_d;
  logic [1:0]    state_q,  state_d;
  logic [2:0]    lock_q,   lock_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [7:0]    err_cnt_q,  err_cnt_d;

  logic       w_push, w_pop, w_empty, w_full;
  logic       w_hd_head, w_hd_tail, w_route_ok;
  logic [2:0] w_hd_route;
  logic [2:0] w_out_valid;
  logic       w_drop_inc, w_err_inc;

  assign w_empty    = (count_q == '0);
  assign w_full     = (count_q == FULL_CNT);
  assign w_push     = bus.in_valid && !w_full;
  assign w_hd_head  = mem_head_q[rd_ptr_q];
  assign w_hd_tail  = mem_tail_q[rd_ptr_q];
  assign w_hd_route = mem_route_q[rd_ptr_q];
  assign w_route_ok = (w_hd_route == 3'b001) || (w_hd_route == 3'b010) ||
                      (w_hd_route == 3'b100);

  // Packet steering: decide port valids, pop, and next FSM/lock/counter events
  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    w_out_valid = 3'b000;
    w_pop       = 1'b0;
    w_drop_inc  = 1'b0;
    w_err_inc   = 1'b0;
    if (!w_empty) begin
      case (state_q)
        ST_IDLE: begin
          if (w_hd_head && w_route_ok) begin
            w_out_valid = w_hd_route;
            w_pop       = |(w_hd_route & bus.out_ready);
            if (w_pop && !w_hd_tail) begin
              state_d = ST_LOCKED;
              lock_d  = w_hd_route;
            end
          end else if (w_hd_head) begin
            w_pop      = 1'b1;
            w_drop_inc = 1'b1;
            if (!w_hd_tail) state_d = ST_DROP;
          end else begin
            w_pop     = 1'b1;
            w_err_inc = 1'b1;
          end
        end
        ST_LOCKED: begin
          w_out_valid = lock_q;
          w_pop       = |(lock_q & bus.out_ready);
          if (w_pop && w_hd_tail) begin
            state_d = ST_IDLE;
            lock_d  = 3'b000;
          end
        end
        ST_DROP: begin
          w_pop = 1'b1;
          if (w_hd_tail) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Occupancy and saturating counters next-state
  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop)      count_d = count_q + (AW+1)'(1);
    else if (!w_push && w_pop) count_d = count_q - (AW+1)'(1);
    drop_cnt_d = drop_cnt_q;
    if (w_drop_inc && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    err_cnt_d = err_cnt_q;
    if (w_err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  // FIFO entry write on accepted flit
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_data_q[wr_ptr_q]  <= bus.in_data;
      mem_head_q[wr_ptr_q]  <= bus.in_head;
      mem_tail_q[wr_ptr_q]  <= bus.in_tail;
      mem_route_q[wr_ptr_q] <= bus.in_route;
    end
  end

  // Control state, pointers and counters with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      lock_q     <= 3'b000;
      drop_cnt_q <= 8'd0;
      err_cnt_q  <= 8'd0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      state_q    <= state_d;
      lock_q     <= lock_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = mem_data_q[rd_ptr_q];
  assign bus.out_tail  = w_hd_tail;
  assign bus.busy      = (state_q != ST_IDLE) || !w_empty;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_route_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_route_out_stage
// Description : Directed self-checking bench for route_out_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_route_out_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  route_out_stage_if #(.DATA_W(30)) bus ();

  route_out_stage #(.DATA_W(30), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d passed=%0d", total, passed);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [29:0] d, input logic h, input logic t, input logic [2:0] r);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_head  = h;
    bus.in_tail  = t;
    bus.in_route = r;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_head = 1'b0;
    bus.in_tail = 1'b0;
    bus.in_route = 3'b000;
    bus.out_ready = 3'b000;
    tick();
    tick();
    // Reset state
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_drop", 32'(bus.drop_cnt), 32'd0);
    check("rst_err", 32'(bus.err_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single-flit packet, no bypass before the accept edge
    bus.out_ready = 3'b111;
    bus.in_valid = 1'b1;
    bus.in_data = 30'h2A;
    bus.in_head = 1'b1;
    bus.in_tail = 1'b1;
    bus.in_route = 3'b010;
    #1;
    check("nobypass_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("single_valid", 32'(bus.out_valid), 32'b010);
    check("single_data", 32'(bus.out_data), 32'h2A);
    check("single_tail", 32'(bus.out_tail), 32'd1);
    check("single_busy", 32'(bus.busy), 32'd1);
    tick();
    check("single_busy_after", 32'(bus.busy), 32'd0);
    check("single_valid_after", 32'(bus.out_valid), 32'd0);

    // Four-flit packet to port 2, ready toggling; body route fields are junk
    bus.out_ready = 3'b000;
    push(30'h100, 1'b1, 1'b0, 3'b100);
    push(30'h101, 1'b0, 1'b0, 3'b000);
    push(30'h102, 1'b0, 1'b0, 3'b011);
    push(30'h103, 1'b0, 1'b1, 3'b001);
    check("four_full", 32'(bus.in_ready), 32'd0);
    for (int c = 0, k = 0; c < 7; c++) begin
      bus.out_ready = (c % 2 == 0) ? 3'b111 : 3'b011;
      check("four_valid", 32'(bus.out_valid), 32'b100);
      check("four_data", 32'(bus.out_data), 32'h100 + 32'(k));
      check("four_tail", 32'(bus.out_tail), (k == 3) ? 32'd1 : 32'd0);
      tick();
      if (c % 2 == 0) k++;
    end
    check("four_idle_valid", 32'(bus.out_valid), 32'd0);
    check("four_idle_busy", 32'(bus.busy), 32'd0);

    // Backpressure: fifth flit held until a pop frees a slot
    bus.out_ready = 3'b000;
    push(30'h200, 1'b1, 1'b0, 3'b001);
    push(30'h201, 1'b0, 1'b0, 3'b000);
    push(30'h202, 1'b0, 1'b0, 3'b000);
    check("bp_ready_3", 32'(bus.in_ready), 32'd1);
    push(30'h203, 1'b0, 1'b1, 3'b000);
    check("bp_ready_4", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data = 30'h204;
    bus.in_head = 1'b1;
    bus.in_tail = 1'b1;
    bus.in_route = 3'b001;
    tick();
    check("bp_held", 32'(bus.in_ready), 32'd0);
    check("bp_head_data", 32'(bus.out_data), 32'h200);
    bus.out_ready = 3'b001;
    tick();
    check("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_d202", 32'(bus.out_data), 32'h202);
    tick();
    check("bp_d203", 32'(bus.out_data), 32'h203);
    tick();
    check("bp_d204_valid", 32'(bus.out_valid), 32'b001);
    check("bp_d204", 32'(bus.out_data), 32'h204);
    tick();
    check("bp_busy", 32'(bus.busy), 32'd0);

    // Invalid route 011: whole packet dropped
    bus.out_ready = 3'b111;
    push(30'h300, 1'b1, 1'b0, 3'b011);
    check("drop_v0", 32'(bus.out_valid), 32'd0);
    push(30'h301, 1'b0, 1'b0, 3'b000);
    check("drop_v1", 32'(bus.out_valid), 32'd0);
    push(30'h302, 1'b0, 1'b1, 3'b000);
    check("drop_v2", 32'(bus.out_valid), 32'd0);
    tick();
    check("drop_cnt", 32'(bus.drop_cnt), 32'd1);
    check("drop_busy", 32'(bus.busy), 32'd0);
    push(30'h310, 1'b1, 1'b1, 3'b100);
    check("drop_next_valid", 32'(bus.out_valid), 32'b100);
    check("drop_next_data", 32'(bus.out_data), 32'h310);
    tick();

    // Orphan flits
    push(30'h400, 1'b0, 1'b0, 3'b001);
    check("orphan_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("orphan_err1", 32'(bus.err_cnt), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_head = 1'b0;
    bus.in_tail = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.in_data = 30'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("orphan_sat", 32'(bus.err_cnt), 32'd255);
    check("orphan_drop_kept", 32'(bus.drop_cnt), 32'd1);

    // Reset in the middle of a packet
    bus.out_ready = 3'b000;
    push(30'h500, 1'b1, 1'b0, 3'b010);
    push(30'h501, 1'b0, 1'b0, 3'b000);
    check("mid_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_valid", 32'(bus.out_valid), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_drop", 32'(bus.drop_cnt), 32'd0);
    check("mid_err", 32'(bus.err_cnt), 32'd0);
    bus.out_ready = 3'b001;
    push(30'h510, 1'b1, 1'b1, 3'b001);
    check("mid_new_valid", 32'(bus.out_valid), 32'b001);
    check("mid_new_data", 32'(bus.out_data), 32'h510);
    tick();
    check("mid_new_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
